// File: rtl/bkm_chk_pkg.sv
// bkm_chk_pkg: shared definitions for the BKM delta tracker.
//   - rpt_state_e : report FSM encodings (IDLE=0, CAPT=1, HOLD=2)
//   - ch_off      : bit offset of channel c in a flat NCH*W bus
package bkm_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_HOLD = 2'd2
    } rpt_state_e;

    // Counters saturate at all-ones and first_err idles at all-ones.
    // Both are expressed as '1 at the use site, so they follow CW.
    localparam bit SAT_AT_ONES = 1'b1;

    function automatic int unsigned ch_off(input int unsigned c, input int unsigned w);
        return c * w;
    endfunction

endpackage

// File: rtl/bkm_delta_chan.sv
// bkm_delta_chan: statistics for one channel of result-vs-expected deltas.
// Ports:
//   clk, arst_n, srst        clock, async active-low reset, sync reset
//   acc                      sample accepted this cycle
//   exp_val, res_val         expected / observed value (W bits)
//   tol_war, tol_err         unsigned tolerances
//   delta, war, err          registered delta and flags of last sample
//   sticky_err               any error since reset
//   max_v, min_v             running signed max/min of delta
//   err_cnt, war_cnt, smp_cnt saturating counters
//   first_err                smp_cnt at first error, all-ones if none
module bkm_delta_chan
    import bkm_chk_pkg::*;
#(
    parameter int W  = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          srst,
    input  logic          acc,
    input  logic [W-1:0]  exp_val,
    input  logic [W-1:0]  res_val,
    input  logic [W-1:0]  tol_war,
    input  logic [W-1:0]  tol_err,
    output logic [W-1:0]  delta,
    output logic          war,
    output logic          err,
    output logic          sticky_err,
    output logic [W-1:0]  max_v,
    output logic [W-1:0]  min_v,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] war_cnt,
    output logic [CW-1:0] smp_cnt,
    output logic [CW-1:0] first_err
);

    logic [W-1:0] delta_c;
    logic [W:0]   mag;
    logic         err_c, war_c, seen;

    assign delta_c = res_val - exp_val;
    // One extra bit so |most-negative| is representable.
    assign mag   = delta_c[W-1] ? ({1'b0, ~delta_c} + {{W{1'b0}}, 1'b1}) : {1'b0, delta_c};
    assign err_c = mag > {1'b0, tol_err};
    assign war_c = (mag > {1'b0, tol_war}) && !err_c;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            delta <= '0; war <= 1'b0; err <= 1'b0; sticky_err <= 1'b0; seen <= 1'b0;
            max_v <= '0; min_v <= '0;
            err_cnt <= '0; war_cnt <= '0; smp_cnt <= '0; first_err <= '1;
        end else if (srst) begin
            delta <= '0; war <= 1'b0; err <= 1'b0; sticky_err <= 1'b0; seen <= 1'b0;
            max_v <= '0; min_v <= '0;
            err_cnt <= '0; war_cnt <= '0; smp_cnt <= '0; first_err <= '1;
        end else if (acc) begin
            delta <= delta_c;
            war   <= war_c;
            err   <= err_c;
            seen  <= 1'b1;
            if (!seen) begin
                max_v <= delta_c;
                min_v <= delta_c;
            end else begin
                if ($signed(delta_c) > $signed(max_v)) max_v <= delta_c;
                if ($signed(delta_c) < $signed(min_v)) min_v <= delta_c;
            end
            if (SAT_AT_ONES && smp_cnt != '1) smp_cnt <= smp_cnt + 1'b1;
            if (war_c && war_cnt != '1)       war_cnt <= war_cnt + 1'b1;
            if (err_c) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                // sticky_err doubles as "an error was already seen", so a
                // saturated smp_cnt cannot be confused with the idle value.
                if (!sticky_err) first_err <= smp_cnt;
                sticky_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bkm_delta_tracker.sv
// bkm_delta_tracker: NCH-channel delta statistics with a req/ack snapshot port.
// Ports:
//   clk, arst_n, srst                 clock, async active-low reset, sync reset
//   enable, tb_valid                  sample acceptance (global, per channel)
//   tb_exp, res_val                   packed NCH*W expected / observed values
//   tol_war, tol_err                  unsigned tolerances
//   delta, war, err, sticky_err       per-channel live outputs
//   rpt_req, rpt_ch, rpt_ack          report handshake inputs
//   rpt_valid, rpt_bad, rpt_*         frozen snapshot of the selected channel
module bkm_delta_tracker
    import bkm_chk_pkg::*;
#(
    parameter int W       = 64,
    parameter int NCH     = 4,
    parameter int LOG2NCH = 2,
    parameter int CW      = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               srst,
    input  logic               enable,
    input  logic [NCH-1:0]     tb_valid,
    input  logic [NCH*W-1:0]   tb_exp,
    input  logic [NCH*W-1:0]   res_val,
    input  logic [W-1:0]       tol_war,
    input  logic [W-1:0]       tol_err,
    output logic [NCH*W-1:0]   delta,
    output logic [NCH-1:0]     war,
    output logic [NCH-1:0]     err,
    output logic [NCH-1:0]     sticky_err,
    input  logic               rpt_req,
    input  logic [LOG2NCH-1:0] rpt_ch,
    input  logic               rpt_ack,
    output logic               rpt_valid,
    output logic               rpt_bad,
    output logic [W-1:0]       rpt_max,
    output logic [W-1:0]       rpt_min,
    output logic [CW-1:0]      rpt_err_cnt,
    output logic [CW-1:0]      rpt_war_cnt,
    output logic [CW-1:0]      rpt_smp_cnt,
    output logic [CW-1:0]      rpt_first_err
);

    logic [NCH-1:0][W-1:0]  max_a, min_a;
    logic [NCH-1:0][CW-1:0] err_cnt_a, war_cnt_a, smp_cnt_a, first_a;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        bkm_delta_chan #(.W(W), .CW(CW)) u_chan (
            .clk        (clk),
            .arst_n     (arst_n),
            .srst       (srst),
            .acc        (enable && tb_valid[c]),
            .exp_val    (tb_exp[ch_off(c, W) +: W]),
            .res_val    (res_val[ch_off(c, W) +: W]),
            .tol_war    (tol_war),
            .tol_err    (tol_err),
            .delta      (delta[ch_off(c, W) +: W]),
            .war        (war[c]),
            .err        (err[c]),
            .sticky_err (sticky_err[c]),
            .max_v      (max_a[c]),
            .min_v      (min_a[c]),
            .err_cnt    (err_cnt_a[c]),
            .war_cnt    (war_cnt_a[c]),
            .smp_cnt    (smp_cnt_a[c]),
            .first_err  (first_a[c])
        );
    end

    rpt_state_e           state_q, state_d;
    logic [LOG2NCH-1:0]   ch_q;
    logic                 sel_bad;
    logic [W-1:0]         sel_max, sel_min;
    logic [CW-1:0]        sel_err, sel_war, sel_smp, sel_first;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rpt_req) state_d = ST_CAPT;
            ST_CAPT: state_d = ST_HOLD;
            ST_HOLD: if (rpt_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)   state_q <= ST_IDLE;
        else if (srst) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Out-of-range selects fall through to the reset-like defaults.
    assign sel_bad = {1'b0, ch_q} >= (LOG2NCH+1)'(NCH);

    always_comb begin
        sel_max = '0; sel_min = '0;
        sel_err = '0; sel_war = '0; sel_smp = '0; sel_first = '1;
        for (int c = 0; c < NCH; c++) begin
            if ({1'b0, ch_q} == (LOG2NCH+1)'(c)) begin
                sel_max   = max_a[c];
                sel_min   = min_a[c];
                sel_err   = err_cnt_a[c];
                sel_war   = war_cnt_a[c];
                sel_smp   = smp_cnt_a[c];
                sel_first = first_a[c];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ch_q <= '0; rpt_valid <= 1'b0; rpt_bad <= 1'b0;
            rpt_max <= '0; rpt_min <= '0;
            rpt_err_cnt <= '0; rpt_war_cnt <= '0; rpt_smp_cnt <= '0; rpt_first_err <= '1;
        end else if (srst) begin
            ch_q <= '0; rpt_valid <= 1'b0; rpt_bad <= 1'b0;
            rpt_max <= '0; rpt_min <= '0;
            rpt_err_cnt <= '0; rpt_war_cnt <= '0; rpt_smp_cnt <= '0; rpt_first_err <= '1;
        end else begin
            if (state_q == ST_IDLE && rpt_req) ch_q <= rpt_ch;
            // Stats registered at the request edge are already visible here.
            if (state_q == ST_CAPT) begin
                rpt_valid     <= 1'b1;
                rpt_bad       <= sel_bad;
                rpt_max       <= sel_max;
                rpt_min       <= sel_min;
                rpt_err_cnt   <= sel_err;
                rpt_war_cnt   <= sel_war;
                rpt_smp_cnt   <= sel_smp;
                rpt_first_err <= sel_first;
            end
            if (state_q == ST_HOLD && rpt_ack) rpt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bkm_delta_tracker.sv
module tb_bkm_delta_tracker;

    localparam int W = 16, NCH = 3, LOG2NCH = 2, CW = 4;

    logic               clk = 1'b0;
    logic               arst_n, srst, enable;
    logic [NCH-1:0]     tb_valid;
    logic [NCH*W-1:0]   tb_exp, res_val;
    logic [W-1:0]       tol_war, tol_err;
    logic [NCH*W-1:0]   delta;
    logic [NCH-1:0]     war, err, sticky_err;
    logic               rpt_req, rpt_ack, rpt_valid, rpt_bad;
    logic [LOG2NCH-1:0] rpt_ch;
    logic [W-1:0]       rpt_max, rpt_min;
    logic [CW-1:0]      rpt_err_cnt, rpt_war_cnt, rpt_smp_cnt, rpt_first_err;

    int n_chk = 0, n_err = 0;

    bkm_delta_tracker #(.W(W), .NCH(NCH), .LOG2NCH(LOG2NCH), .CW(CW)) dut (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
        .tb_valid(tb_valid), .tb_exp(tb_exp), .res_val(res_val),
        .tol_war(tol_war), .tol_err(tol_err),
        .delta(delta), .war(war), .err(err), .sticky_err(sticky_err),
        .rpt_req(rpt_req), .rpt_ch(rpt_ch), .rpt_ack(rpt_ack),
        .rpt_valid(rpt_valid), .rpt_bad(rpt_bad),
        .rpt_max(rpt_max), .rpt_min(rpt_min),
        .rpt_err_cnt(rpt_err_cnt), .rpt_war_cnt(rpt_war_cnt),
        .rpt_smp_cnt(rpt_smp_cnt), .rpt_first_err(rpt_first_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [W-1:0] e, input logic [W-1:0] r);
        tb_exp[ch*W +: W]  = e;
        res_val[ch*W +: W] = r;
        tb_valid           = '0;
        tb_valid[ch]       = 1'b1;
    endtask

    task automatic smp(input int ch, input logic [W-1:0] e, input logic [W-1:0] r);
        put(ch, e, r);
        tick();
        tb_valid = '0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !rpt_valid; i++) tick();
        chk("rpt_valid_rise", 64'(rpt_valid), 64'd1);
    endtask

    task automatic req(input int ch);
        rpt_req = 1'b1;
        rpt_ch  = LOG2NCH'(ch);
        tick();
        rpt_req = 1'b0;
        wait_valid();
    endtask

    task automatic ack();
        rpt_ack = 1'b1;
        tick();
        rpt_ack = 1'b0;
        chk("rpt_valid_drop", 64'(rpt_valid), 64'd0);
    endtask

    task automatic chk_rpt(input string tag, input logic [W-1:0] mx, input logic [W-1:0] mn,
                           input logic [CW-1:0] ec, input logic [CW-1:0] wc,
                           input logic [CW-1:0] sc, input logic [CW-1:0] fe);
        chk({tag, ".max"},   64'(rpt_max),       64'(mx));
        chk({tag, ".min"},   64'(rpt_min),       64'(mn));
        chk({tag, ".err"},   64'(rpt_err_cnt),   64'(ec));
        chk({tag, ".war"},   64'(rpt_war_cnt),   64'(wc));
        chk({tag, ".smp"},   64'(rpt_smp_cnt),   64'(sc));
        chk({tag, ".first"}, 64'(rpt_first_err), 64'(fe));
    endtask

    initial begin
        arst_n = 1'b0; srst = 1'b0; enable = 1'b1; tb_valid = '0;
        tb_exp = '0; res_val = '0; tol_war = 16'd2; tol_err = 16'd8;
        rpt_req = 1'b0; rpt_ack = 1'b0; rpt_ch = '0;
        #12;
        chk("rst.rpt_valid", 64'(rpt_valid), 64'd0);
        chk("rst.first_err", 64'(rpt_first_err), 64'hF);
        chk("rst.delta", 64'(delta), 64'd0);
        chk("rst.sticky", 64'(sticky_err), 64'd0);
        arst_n = 1'b1;
        tick();

        // ch0: deltas 1, 3, -9, 0
        smp(0, 16'd100, 16'd101);
        chk("t1.s0.flags", 64'({war[0], err[0]}), 64'b00);
        smp(0, 16'd100, 16'd103);
        chk("t1.s1.flags", 64'({war[0], err[0]}), 64'b10);
        tick();
        chk("t1.hold.war", 64'(war[0]), 64'd1);
        chk("t1.hold.delta", 64'(delta[15:0]), 64'd3);
        smp(0, 16'd100, 16'd91);
        chk("t1.s2.flags", 64'({war[0], err[0]}), 64'b01);
        chk("t1.s2.delta", 64'(delta[15:0]), 64'hFFF7);
        smp(0, 16'd100, 16'd100);
        chk("t1.s3.flags", 64'({war[0], err[0]}), 64'b00);
        req(0);
        chk("t1.bad", 64'(rpt_bad), 64'd0);
        chk_rpt("t1", 16'd3, 16'hFFF7, 4'd1, 4'd1, 4'd4, 4'd2);
        ack();

        // enable low: sample ignored
        enable = 1'b0;
        smp(0, 16'd0, 16'd50);
        chk("en.delta", 64'(delta[15:0]), 64'd0);
        enable = 1'b1;

        // ch1: only negative deltas
        tol_err = 16'd100;
        smp(1, 16'd10, 16'd5);
        smp(1, 16'd10, 16'd8);
        req(1);
        chk_rpt("t2", 16'hFFFE, 16'hFFFB, 4'd0, 4'd1, 4'd2, 4'hF);
        ack();
        tol_err = 16'd8;

        // ch2: most-negative delta
        smp(2, 16'h8000, 16'h0000);
        chk("t3.delta", 64'(delta[47:32]), 64'h8000);
        chk("t3.err", 64'(err[2]), 64'd1);
        chk("t3.sticky", 64'(sticky_err), 64'b101);

        // ch2: 19 more errors -> counters saturate at 15
        for (int i = 0; i < 19; i++) smp(2, 16'd0, 16'd100);
        req(2);
        chk_rpt("t4", 16'd100, 16'h8000, 4'd15, 4'd0, 4'd15, 4'd0);
        ack();

        // sample in the request cycle is included
        put(0, 16'd100, 16'd104);
        rpt_req = 1'b1; rpt_ch = 2'd0;
        tick();
        rpt_req = 1'b0; tb_valid = '0;
        wait_valid();
        chk_rpt("t5a", 16'd4, 16'hFFF7, 4'd1, 4'd2, 4'd5, 4'd2);
        // sample and a stray request during HOLD
        put(0, 16'd100, 16'd120);
        rpt_req = 1'b1; rpt_ch = 2'd1;
        tick();
        tb_valid = '0; rpt_req = 1'b0;
        chk("t5.live.err", 64'(err[0]), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("t5.hold.valid", 64'(rpt_valid), 64'd1);
        chk_rpt("t5b", 16'd4, 16'hFFF7, 4'd1, 4'd2, 4'd5, 4'd2);
        ack();
        tick();
        chk("t5.no_stray", 64'(rpt_valid), 64'd0);
        req(0);
        chk_rpt("t5c", 16'd20, 16'hFFF7, 4'd2, 4'd2, 4'd6, 4'd2);
        ack();

        // out-of-range channel
        req(3);
        chk("t6.bad", 64'(rpt_bad), 64'd1);
        chk_rpt("t6", 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 4'hF);
        ack();

        // srst during HOLD
        req(1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst.valid", 64'(rpt_valid), 64'd0);
        chk("srst.sticky", 64'(sticky_err), 64'd0);
        req(1);
        chk_rpt("srst", 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 4'hF);
        ack();

        // async reset mid-HOLD
        smp(0, 16'd0, 16'd20);
        req(0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(rpt_valid), 64'd0);
        chk("arst.delta", 64'(delta), 64'd0);
        chk("arst.sticky", 64'(sticky_err), 64'd0);
        arst_n = 1'b1;
        tick();
        req(0);
        chk("arst.bad", 64'(rpt_bad), 64'd0);
        chk_rpt("arst", 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 4'hF);
        ack();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
